// File: rtl/freq_pkg.sv
// freq_pkg: shared constants and types for the programmable clock divider.
//   FREQ_W_DEF / FREQ_NCH_DEF : default counter width and channel count
//   DIV_1S / DIV_1MS          : divisors for 1 s and 1 ms periods at 50 MHz
//   freq_div_t                : default-width divisor/counter type
//   sel_w()                   : channel-select width, never below 1 bit
package freq_pkg;

   localparam int unsigned FREQ_W_DEF   = 32;
   localparam int unsigned FREQ_NCH_DEF = 2;
   localparam int unsigned DIV_1S       = 50_000_000;
   localparam int unsigned DIV_1MS      = 50_000;

   typedef logic [FREQ_W_DEF-1:0] freq_div_t;

   function automatic int unsigned sel_w(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/freq_div_ch.sv
// freq_div_ch: one divider channel.
//   reloje   in  system clock (rising edge)
//   reset_n  in  asynchronous active-low reset
//   en       in  count enable
//   ld       in  load strobe: div <= div_val, restart phase
//   clr      in  phase clear: cnt/tick/relojs to 0, divisor kept
//   div_val  in  W  new divisor
//   tick     out one-cycle pulse every div cycles
//   relojs   out toggles on every tick
//   busy     out divisor is non-zero
module freq_div_ch
   import freq_pkg::*;
#(
   parameter int unsigned  W       = FREQ_W_DEF,
   parameter logic [W-1:0] DIV_RST = W'(DIV_1S)
)(
   input  logic         reloje,
   input  logic         reset_n,
   input  logic         en,
   input  logic         ld,
   input  logic         clr,
   input  logic [W-1:0] div_val,
   output logic         tick,
   output logic         relojs,
   output logic         busy
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] div;
   logic [W-1:0] cnt;
   logic         halted;
   logic         terminal;

   always_comb begin
      halted   = (div == '0);
      terminal = (cnt == div - ONE);
      busy     = !halted;
   end

   // clr and ld both restart the phase; the divisor write is independent so
   // that a load coinciding with a clear still takes effect.
   always_ff @(posedge reloje or negedge reset_n) begin
      if (!reset_n) begin
         div    <= DIV_RST;
         cnt    <= '0;
         tick   <= 1'b0;
         relojs <= 1'b0;
      end else begin
         if (ld)
            div <= div_val;
         if (clr || ld) begin
            cnt    <= '0;
            tick   <= 1'b0;
            relojs <= 1'b0;
         end else if (!en) begin
            tick <= 1'b0;
         end else if (halted) begin
            cnt  <= '0;
            tick <= 1'b0;
         end else if (terminal) begin
            cnt    <= '0;
            tick   <= 1'b1;
            relojs <= !relojs;
         end else begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/freq_div_multi.sv
// freq_div_multi: N_CH independent programmable clock dividers on reloje.
//   reloje   in  system clock (rising edge)
//   reset_n  in  asynchronous active-low reset
//   en       in  global count enable
//   div_ld   in  load strobe for channel ch_sel
//   ch_sel   in  channel addressed by div_ld (out-of-range ignored)
//   div_val  in  W  new divisor
//   sync_clr in  (FREQ_SYNC_CLR_EN only) clear phase of every channel
//   tick     out N_CH one-cycle pulse per channel period
//   relojs   out N_CH divided clock, toggles on each tick
//   busy     out N_CH channel divisor non-zero
// Optional feature macro: FREQ_SYNC_CLR_EN
module freq_div_multi
   import freq_pkg::*;
#(
   parameter int unsigned  N_CH    = FREQ_NCH_DEF,
   parameter int unsigned  W       = FREQ_W_DEF,
   parameter logic [W-1:0] DIV_RST = W'(DIV_1S)
)(
   input  logic                     reloje,
   input  logic                     reset_n,
   input  logic                     en,
   input  logic                     div_ld,
   input  logic [sel_w(N_CH)-1:0]   ch_sel,
   input  logic [W-1:0]             div_val,
`ifdef FREQ_SYNC_CLR_EN
   input  logic                     sync_clr,
`endif
   output logic [N_CH-1:0]          tick,
   output logic [N_CH-1:0]          relojs,
   output logic [N_CH-1:0]          busy
);

   localparam int unsigned SW = sel_w(N_CH);

   logic [N_CH-1:0] ld;
   logic            clr;

`ifdef FREQ_SYNC_CLR_EN
   assign clr = sync_clr;
`else
   assign clr = 1'b0;
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      // ch_sel values >= N_CH match no channel, so such loads are dropped
      assign ld[i] = div_ld && (ch_sel == SW'(i));

      freq_div_ch #(
         .W       (W),
         .DIV_RST (DIV_RST)
      ) u_ch (
         .reloje  (reloje),
         .reset_n (reset_n),
         .en      (en),
         .ld      (ld[i]),
         .clr     (clr),
         .div_val (div_val),
         .tick    (tick[i]),
         .relojs  (relojs[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: tb/tb_freq_div_multi.sv
module tb_freq_div_multi;

   localparam int NCH = 3;

   logic        reloje = 1'b0;
   logic        reset_n;
   logic        en;
   logic        div_ld;
   logic [1:0]  ch_sel;
   logic [31:0] div_val;
`ifdef FREQ_SYNC_CLR_EN
   logic        sync_clr;
`endif
   logic [2:0]  tick, relojs, busy;

   freq_div_multi #(
      .N_CH    (NCH),
      .W       (32),
      .DIV_RST (32'd4)
   ) dut (
      .reloje  (reloje),
      .reset_n (reset_n),
      .en      (en),
      .div_ld  (div_ld),
      .ch_sel  (ch_sel),
      .div_val (div_val),
`ifdef FREQ_SYNC_CLR_EN
      .sync_clr(sync_clr),
`endif
      .tick    (tick),
      .relojs  (relojs),
      .busy    (busy)
   );

   always #5 reloje = ~reloje;

   int errors = 0;
   int checks = 0;

   // Reference: each channel tracks enabled cycles elapsed since its phase
   // origin (reset, load or clear). Ticks fall on multiples of div, and
   // relojs is the parity of the number of completed periods.
   longint unsigned m_div [NCH];
   longint unsigned m_el  [NCH];
   logic [2:0]      m_tick;

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_div[c] = 4;
         m_el[c]  = 0;
      end
      m_tick = '0;
   endfunction

   function automatic logic [2:0] exp_relojs();
      logic [2:0] r;
      r = '0;
      for (int c = 0; c < NCH; c++)
         if (m_div[c] != 0)
            r[c] = ((m_el[c] / m_div[c]) % 2) == 1;
      return r;
   endfunction

   function automatic logic [2:0] exp_busy();
      logic [2:0] b;
      for (int c = 0; c < NCH; c++)
         b[c] = (m_div[c] != 0);
      return b;
   endfunction

   task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic e, input logic l, input logic [1:0] s,
                       input logic [31:0] v, input logic sc);
      en      = e;
      div_ld  = l;
      ch_sel  = s;
      div_val = v;
`ifdef FREQ_SYNC_CLR_EN
      sync_clr = sc;
`endif
      @(posedge reloje);
      for (int c = 0; c < NCH; c++) begin
         if (sc) begin
            m_el[c]   = 0;
            m_tick[c] = 1'b0;
            if (l && int'(s) == c) m_div[c] = longint'(v);
         end else if (l && int'(s) == c) begin
            m_div[c]  = longint'(v);
            m_el[c]   = 0;
            m_tick[c] = 1'b0;
         end else if (e && m_div[c] != 0) begin
            m_el[c]   = m_el[c] + 1;
            m_tick[c] = (m_el[c] % m_div[c]) == 0;
         end else begin
            m_tick[c] = 1'b0;
         end
      end
      #1;
      check3("model_tick",   tick,   m_tick);
      check3("model_relojs", relojs, exp_relojs());
      check3("model_busy",   busy,   exp_busy());
      div_ld = 1'b0;
`ifdef FREQ_SYNC_CLR_EN
      sync_clr = 1'b0;
`endif
   endtask

   typedef struct {
      logic        e;
      logic        l;
      logic [1:0]  s;
      logic [31:0] v;
      logic [2:0]  t;
      logic [2:0]  r;
      logic [2:0]  b;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int cnt_t;
      int first0, first1, first2;
      logic [1:0]  rs;
      logic [31:0] rv;
      int          rk;

      // edge-by-edge expectations from reset release, all channels div=4
      tbl[0]  = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111};
      tbl[1]  = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111};
      tbl[2]  = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111};
      tbl[3]  = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b111, 3'b111, 3'b111};
      tbl[4]  = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b111, 3'b111};
      tbl[5]  = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b111, 3'b111};
      tbl[6]  = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b111, 3'b111};
      tbl[7]  = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b111, 3'b000, 3'b111};
      tbl[8]  = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111};
      tbl[9]  = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111};
      tbl[10] = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111};
      tbl[11] = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b111, 3'b111, 3'b111};
      tbl[12] = '{1'b1, 1'b1, 2'd1, 32'd1, 3'b000, 3'b101, 3'b111};
      tbl[13] = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b010, 3'b111, 3'b111};
      tbl[14] = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b010, 3'b101, 3'b111};
      tbl[15] = '{1'b1, 1'b0, 2'd0, 32'd0, 3'b111, 3'b010, 3'b111};
      tbl[16] = '{1'b1, 1'b1, 2'd3, 32'd0, 3'b010, 3'b000, 3'b111};

      reset_n = 1'b0;
      en      = 1'b0;
      div_ld  = 1'b0;
      ch_sel  = '0;
      div_val = '0;
`ifdef FREQ_SYNC_CLR_EN
      sync_clr = 1'b0;
`endif
      model_reset();
      #12;
      check3("rst_tick",   tick,   3'b000);
      check3("rst_relojs", relojs, 3'b000);
      check3("rst_busy",   busy,   3'b111);
      @(negedge reloje);
      reset_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].e, tbl[i].l, tbl[i].s, tbl[i].v, 1'b0);
         check3($sformatf("tbl%0d_tick", i),   tick,   tbl[i].t);
         check3($sformatf("tbl%0d_relojs", i), relojs, tbl[i].r);
         check3($sformatf("tbl%0d_busy", i),   busy,   tbl[i].b);
      end

      // halted channel: no ticks, relojs low, busy low; then resume at div 3
      step(1'b1, 1'b1, 2'd0, 32'd0, 1'b0);
      check3("halt_busy", busy & 3'b001, 3'b000);
      cnt_t = 0;
      for (int k = 0; k < 100; k++) begin
         step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
         cnt_t += int'(tick[0]) + int'(relojs[0]);
      end
      check_int("halt_no_tick", cnt_t, 0);
      step(1'b1, 1'b1, 2'd0, 32'd3, 1'b0);
      cnt_t = 0;
      for (int k = 1; k <= 9; k++) begin
         step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
         if (tick[0]) begin
            cnt_t++;
            check_int("div3_tick_pos", k % 3, 0);
         end
      end
      check_int("div3_tick_cnt", cnt_t, 3);

      // enable gap with cnt=2, div=4
      step(1'b1, 1'b1, 2'd0, 32'd4, 1'b0);
      step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      cnt_t = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
         cnt_t += int'(|tick);
      end
      check_int("gap_no_tick", cnt_t, 0);
      step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      check3("gap_resume1", tick & 3'b001, 3'b000);
      step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      check3("gap_resume2", tick & 3'b001, 3'b001);

      // load coincident with terminal count (div 4 -> 6)
      for (int k = 0; k < 3; k++)
         step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      step(1'b1, 1'b1, 2'd0, 32'd6, 1'b0);
      check3("ld_tc_no_tick", tick & 3'b001, 3'b000);
      first0 = 0;
      for (int k = 1; k <= 6; k++) begin
         step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
         if (tick[0] && first0 == 0) first0 = k;
      end
      check_int("ld_tc_next_tick", first0, 6);
      step(1'b1, 1'b1, 2'd3, 32'd7, 1'b0);
      check3("sel3_busy", busy, 3'b111);

`ifdef FREQ_SYNC_CLR_EN
      step(1'b1, 1'b1, 2'd0, 32'd5, 1'b0);
      step(1'b1, 1'b1, 2'd1, 32'd7, 1'b0);
      for (int k = 0; k < 3; k++)
         step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
      check3("clr_tick",   tick,   3'b000);
      check3("clr_relojs", relojs, 3'b000);
      first0 = 0; first1 = 0; first2 = 0;
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
         if (tick[0] && first0 == 0) first0 = k;
         if (tick[1] && first1 == 0) first1 = k;
         if (tick[2] && first2 == 0) first2 = k;
      end
      check_int("clr_first_ch0", first0, 5);
      check_int("clr_first_ch1", first1, 7);
      check_int("clr_first_ch2", first2, 4);
      step(1'b0, 1'b1, 2'd2, 32'd2, 1'b1);
`endif

      // reset asserted mid-cycle takes effect without waiting for a clock
      @(posedge reloje);
      #3;
      reset_n = 1'b0;
      #1;
      check3("midrst_tick",   tick,   3'b000);
      check3("midrst_relojs", relojs, 3'b000);
      check3("midrst_busy",   busy,   3'b111);
      model_reset();
      @(negedge reloje);
      reset_n = 1'b1;

      // randomized traffic, including out-of-range selects and all-ones divisors
      for (int n = 0; n < 3000; n++) begin
         rs = 2'($urandom_range(0, 3));
         rk = int'($urandom_range(0, 9));
         if (rk == 0)      rv = 32'd0;
         else if (rk == 9) rv = 32'hFFFF_FFFF;
         else              rv = 32'($urandom_range(1, 8));
         step($urandom_range(0, 9) != 0,
              $urandom_range(0, 19) == 0,
              rs, rv,
`ifdef FREQ_SYNC_CLR_EN
              $urandom_range(0, 49) == 0
`else
              1'b0
`endif
              );
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/freq_div_multi.md
Name: freq_div_multi

Overview:
Parametrised, programmable multi-channel clock divider; successor to the fixed 1 s divider.
- Each channel has a runtime-loadable divisor.
- Each channel produces a one-cycle `tick` enable and a 50%-style toggled output `relojs`.
- Feeds the dispensing-machine timers, display refresh and debounce logic from a single `reloje` domain.

Parameters:
- N_CH, 2, number of independent divider channels (1..8).
- W, 32, counter and divisor width in bits.
- DIV_RST, 50_000_000, divisor value every channel holds after reset.

Ports:
- reloje  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  global count enable.
- div_ld  in  1  load strobe for the divisor of channel `ch_sel`.
- ch_sel  in  $clog2(N_CH) (min 1)  channel addressed by `div_ld`.
- div_val  in  W  new divisor value.
- tick  out  N_CH  one-cycle pulse per channel at each divisor period.
- relojs  out  N_CH  per-channel divided clock; toggles on each tick.
- busy  out  N_CH  1 when the channel divisor is non-zero (channel running).

Behaviour:
- Reset (async, reset_n=0):
  - every divisor = DIV_RST;
  - every counter = 0;
  - tick = 0, relojs = 0;
  - busy = (DIV_RST != 0).
- Per-channel counter cnt counts 0..div-1 while en=1.
  - When cnt == div-1: next cycle cnt=0, tick=1 for exactly one cycle, relojs inverts.
  - Otherwise cnt increments and tick=0.
- tick and relojs are registered: tick asserts in the cycle after cnt reaches div-1. Tick period = div cycles. relojs period = 2*div cycles.
- div=1: tick held high every cycle; relojs toggles every cycle.
- div=0: channel halted; cnt held 0, tick=0, relojs holds its value, busy=0.
- en=0: all counters freeze, tick=0, relojs holds, divisors still loadable.
- div_ld=1:
  - On the next edge, div[ch_sel] = div_val, cnt[ch_sel] = 0, tick[ch_sel] = 0, relojs[ch_sel] = 0.
  - Other channels are unaffected.
  - Load has priority over a terminal count in the same cycle: no tick is emitted.
- ch_sel >= N_CH with div_ld=1: ignored, no state change.
- Counter compare uses full W bits; no wrap beyond div-1; `div_val` of all ones is legal.
- Reset asserted mid-count: immediate return to reset values; no partial tick.

Optional Feature:
- Macro FREQ_SYNC_CLR_EN.
- Defined:
  - Adds input port `sync_clr` (1 bit).
  - sync_clr=1 on an edge clears all cnt, tick and relojs to 0 in every channel; divisors are retained.
  - sync_clr has priority over div_ld and over en; a simultaneous div_ld still writes its divisor.
  - Used to phase-align all channels.
- Undefined: no `sync_clr` port; channels are only aligned by reset or individual loads.

Decomposition:
- Package freq_pkg:
  - constants FREQ_W_DEF=32, FREQ_NCH_DEF=2;
  - DIV_1S=50_000_000 and DIV_1MS=50_000 (50 MHz reloje);
  - typedef freq_div_t = logic [FREQ_W_DEF-1:0].
- One sub-module, freq_div_ch: a single channel with divisor register, counter, tick/relojs registers and load/clear logic.
- Top module generates N_CH instances and decodes ch_sel into per-channel load strobes.

Test Plan:
- Reset release, N_CH=2, DIV_RST=4, en=1 → tick[0] high on cycles 4, 8, 12 after release; relojs[0] = 0→1→0 every 4 cycles.
- Load ch 1 with div_val=1 → next cycle onward tick[1]=1 every cycle, relojs[1] toggles each cycle; ch 0 timing unchanged.
- Load div_val=0 on ch 0 → busy[0]=0, tick[0] stays 0 for 100 cycles; relojs[0]=0; reload 3 → ticks resume every 3 cycles.
- en deasserted for 10 cycles with cnt=2, div=4 → no ticks during gap; first tick 2 cycles after en returns.
- div_ld coincident with terminal count on ch 0 (div 4→6) → no tick that cycle; next tick 6 cycles later; ch_sel=3 load ignored.
- (FREQ_SYNC_CLR_EN) channels mid-count (div 5 and 7) + sync_clr pulse → both relojs=0, tick=0; ticks at cycles 5 and 7 after the clear.
